// File: rtl/riscv_inst_decode_queue_if.sv
// Fetch-side enqueue, flush and issue-side decoded-head signals of the decode queue.
// The master drives requests and flush; the slave is the queue itself.
interface riscv_inst_decode_queue_if #(
    parameter int unsigned p_depth = 4,
    parameter int unsigned p_xlen  = 32
);
    localparam int unsigned CntW = $clog2(p_depth) + 1;

    logic              flush;
    logic              in_val;
    logic              in_rdy;
    logic [31:0]       in_msg;
    logic              out_val;
    logic              out_rdy;
    logic [31:0]       out_inst;
    logic [2:0]        out_fmt;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [p_xlen-1:0] out_imm;
    logic              out_illegal;
    logic [CntW-1:0]   count;

    modport master (
        output flush, in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_inst, out_fmt, out_rd, out_rs1, out_rs2,
        input  out_funct3, out_funct7, out_imm, out_illegal, count
    );

    modport slave (
        input  flush, in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_inst, out_fmt, out_rd, out_rs1, out_rs2,
        output out_funct3, out_funct7, out_imm, out_illegal, count
    );
endinterface

// File: rtl/riscv_inst_decode_queue.sv
// Instruction decode queue: classifies each RISC-V word at enqueue and buffers the word,
// its format and its sign-extended immediate in a circular FIFO read directly by issue.
module riscv_inst_decode_queue #(
    parameter int unsigned p_depth = 4,
    parameter int unsigned p_xlen  = 32
) (
    input logic                      clk,
    input logic                      reset,
    riscv_inst_decode_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(p_depth);
    localparam int unsigned CntW = $clog2(p_depth) + 1;
    localparam logic [CntW-1:0] Full = CntW'(p_depth);

    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtSb  = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtUj  = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    logic [31:0]       inst_mem [p_depth];
    logic [2:0]        fmt_mem  [p_depth];
    logic [p_xlen-1:0] imm_mem  [p_depth];
    logic              ill_mem  [p_depth];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic [2:0]        dec_fmt;
    logic [31:0]       dec_imm32;
    logic [p_xlen-1:0] dec_imm;
    logic [31:0]       m;
    logic              enq, deq;

    assign m = bus.in_msg;

    always_comb begin
        dec_fmt = FmtIll;
        case (m[6:0])
            7'b0110011:                         dec_fmt = FmtR;
            7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FmtI;
            7'b0100011:                         dec_fmt = FmtS;
            7'b1100011:                         dec_fmt = FmtSb;
            7'b0110111, 7'b0010111:             dec_fmt = FmtU;
            7'b1101111:                         dec_fmt = FmtUj;
            default:                            dec_fmt = FmtIll;
        endcase
    end

    always_comb begin
        dec_imm32 = '0;
        case (dec_fmt)
            FmtI:    dec_imm32 = {{20{m[31]}}, m[31:20]};
            FmtS:    dec_imm32 = {{20{m[31]}}, m[31:25], m[11:7]};
            FmtSb:   dec_imm32 = {{19{m[31]}}, m[31], m[7], m[30:25], m[11:8], 1'b0};
            FmtU:    dec_imm32 = {m[31:12], 12'b0};
            FmtUj:   dec_imm32 = {{11{m[31]}}, m[31], m[19:12], m[20], m[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase
        // Widen to p_xlen: fill with the sign, then overlay the 32-bit value.
        dec_imm        = {p_xlen{dec_imm32[31]}};
        dec_imm[31:0]  = dec_imm32;
    end

    assign bus.in_rdy  = !reset && !bus.flush && (count_q < Full);
    assign bus.out_val = (count_q != '0);
    assign enq         = bus.in_val && bus.in_rdy;
    assign deq         = bus.out_val && bus.out_rdy;

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Entries are cleared on reset so the head fields read as zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(p_depth); i++) begin
                inst_mem[i] <= '0;
                fmt_mem[i]  <= '0;
                imm_mem[i]  <= '0;
                ill_mem[i]  <= 1'b0;
            end
        end else if (enq) begin
            inst_mem[wr_ptr_q] <= m;
            fmt_mem[wr_ptr_q]  <= dec_fmt;
            imm_mem[wr_ptr_q]  <= dec_imm;
            ill_mem[wr_ptr_q]  <= (dec_fmt == FmtIll);
        end
    end

    assign bus.out_inst    = inst_mem[rd_ptr_q];
    assign bus.out_fmt     = fmt_mem[rd_ptr_q];
    assign bus.out_imm     = imm_mem[rd_ptr_q];
    assign bus.out_illegal = ill_mem[rd_ptr_q];
    assign bus.out_rd      = inst_mem[rd_ptr_q][11:7];
    assign bus.out_rs1     = inst_mem[rd_ptr_q][19:15];
    assign bus.out_rs2     = inst_mem[rd_ptr_q][24:20];
    assign bus.out_funct3  = inst_mem[rd_ptr_q][14:12];
    assign bus.out_funct7  = inst_mem[rd_ptr_q][31:25];
    assign bus.count       = count_q;
endmodule
